shift_pipe: RTL and testbench

Parametrised, pipelined barrel shifter for the datapath's operand-2 path. It implements ARM-style LSL/LSR/ASR/ROR/RRX with both immediate and register-specified shift amounts, including the architectural carry-out rules. It uses a two-stage valid/ready pipeline with back-pressure, so it sits between register read and the ALU and can stall with the pipeline. Result flags (zero, negative) are produced alongside the data.

---
 rtl/shift_pkg.sv | 27 ++
 rtl/shift_decode.sv | 46 ++++
 rtl/shift_pipe.sv | 171 +++++++++++++++++
 tb/tb_shift_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared constants and types for the operand-2 barrel shifter pipeline.
// Stage-1 decode results are carried in the structs below.
package shift_pkg;

    localparam logic [1:0] SH_LSL = 2'b00;
    localparam logic [1:0] SH_LSR = 2'b01;
    localparam logic [1:0] SH_ASR = 2'b10;
    localparam logic [1:0] SH_ROR = 2'b11;

    // Decoded operation kind: the raw type plus the special forms stage 2 must handle.
    typedef struct packed {
        logic [1:0] typ;
        logic       rrx;
        logic       pass;
        logic       zfill;
        logic       sfill;
    } kind_t;

    // Width-independent part of the stage-1 decoded op; the operand and tag
    // are appended by the top level, where their widths are known.
    typedef struct packed {
        kind_t      kind;
        logic [7:0] n;
        logic       cin;
    } s1_ctl_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational decode of (type, imm, amt) into the effective shift amount
// and the special-case kind flags used by the shift stage.
module shift_decode
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic [1:0] typ,
    input  logic       imm,
    input  logic [7:0] amt,
    output kind_t      kind,
    output logic [7:0] n
);

    localparam logic [7:0] FULL = 8'(WIDTH);

    logic [SH_W-1:0] imm_amt;

    assign imm_amt = amt[SH_W-1:0];

    // NOTE: every output gets a default at the top of the block so no path
    // leaves one unassigned, which would otherwise infer a latch.
    always_comb begin
        kind     = '0;
        kind.typ = typ;
        n        = amt;

        if (imm) begin
            n = 8'(imm_amt);
            // A zero immediate encodes LSR/ASR #N and RRX; LSL #0 stays a pass.
            if (imm_amt == '0) begin
                case (typ)
                    SH_LSR, SH_ASR: n = FULL;
                    SH_ROR:         kind.rrx = 1'b1;
                    default:        ;
                endcase
            end
        end

        kind.pass  = (n == 8'd0) && !kind.rrx;
        kind.zfill = ((typ == SH_LSL) || (typ == SH_LSR)) && (n >= FULL);
        kind.sfill = (typ == SH_ASR) && (n >= FULL);
    end

endmodule

// File: rtl/shift_pipe.sv
// Two-stage valid/ready barrel shifter: stage 1 decodes the shift, stage 2
// computes data, ARM carry-out and zero/negative flags.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4,
    parameter int SH_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_type,
    input  logic             in_imm,
    input  logic [7:0]       in_amt,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_cin,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_neg,
    output logic [TAG_W-1:0] out_tag
);

    localparam logic [7:0] FULL = 8'(WIDTH);

    typedef struct packed {
        s1_ctl_t          ctl;
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
    } s1_op_t;

    // Right-rotate built as log2(WIDTH) mux levels, one per amount bit.
    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x,
                                              input logic [SH_W-1:0]  r);
        logic [WIDTH-1:0] y;
        y = x;
        for (int k = 0; k < SH_W; k++) begin
            if (r[k]) y = (y >> (1 << k)) | (y << (WIDTH - (1 << k)));
        end
        return y;
    endfunction

    logic   s1_valid;
    logic   s1_adv;
    logic   s2_adv;
    s1_op_t s1_op;
    s1_op_t dec_op;
    kind_t  dec_kind;
    logic [7:0] dec_n;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv && !reset;

    shift_decode #(
        .WIDTH (WIDTH),
        .SH_W  (SH_W)
    ) u_decode (
        .typ  (in_type),
        .imm  (in_imm),
        .amt  (in_amt),
        .kind (dec_kind),
        .n    (dec_n)
    );

    always_comb begin
        dec_op          = '0;
        dec_op.ctl.kind = dec_kind;
        dec_op.ctl.n    = dec_n;
        dec_op.ctl.cin  = in_cin;
        dec_op.data     = in_data;
        dec_op.tag      = in_tag;
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
        end
    end

    // NOTE: the stage-1 payload has no reset; s1_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (s1_adv && in_valid) begin
            s1_op <= dec_op;
        end
    end

    // Stage-2 combinational shift.
    logic [SH_W-1:0]  s;
    logic [SH_W-1:0]  idx_l;
    logic [SH_W-1:0]  idx_r;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] s2_data;
    logic             s2_cout;
    kind_t            k;

    always_comb begin
        k       = s1_op.ctl.kind;
        a       = s1_op.data;
        s       = s1_op.ctl.n[SH_W-1:0];
        // Modulo-N indices: N-s for left shifts, s-1 for right shifts/rotates.
        idx_l   = '0 - s;
        idx_r   = s - SH_W'(1);
        s2_data = a;
        s2_cout = s1_op.ctl.cin;

        if (k.rrx) begin
            s2_data = {s1_op.ctl.cin, a[WIDTH-1:1]};
            s2_cout = a[0];
        end else if (k.pass) begin
            s2_data = a;
        end else if (k.zfill) begin
            s2_data = '0;
            if (s1_op.ctl.n == FULL) s2_cout = (k.typ == SH_LSL) ? a[0] : a[WIDTH-1];
            else                     s2_cout = 1'b0;
        end else if (k.sfill) begin
            s2_data = {WIDTH{a[WIDTH-1]}};
            s2_cout = a[WIDTH-1];
        end else begin
            case (k.typ)
                SH_LSL: begin
                    s2_data = a << s;
                    s2_cout = a[idx_l];
                end
                SH_LSR: begin
                    s2_data = a >> s;
                    s2_cout = a[idx_r];
                end
                SH_ASR: begin
                    s2_data = $signed(a) >>> s;
                    s2_cout = a[idx_r];
                end
                default: begin
                    // n mod N = 0 with n != 0 rotates by zero and yields C = a[N-1].
                    s2_data = rotr(a, s);
                    s2_cout = a[idx_r];
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cout  <= 1'b0;
            out_zero  <= 1'b0;
            out_neg   <= 1'b0;
            out_tag   <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s2_data;
                out_cout <= s2_cout;
                out_zero <= (s2_data == '0);
                out_neg  <= s2_data[WIDTH-1];
                out_tag  <= s1_op.tag;
            end
        end
    end

endmodule

// File: tb/tb_shift_pipe.sv
// Directed bench for shift_pipe: shift/carry vectors, latency, back-pressure
// and reset behaviour with hand-computed expectations.
module tb_shift_pipe;
    import shift_pkg::*;

    localparam int WIDTH = 32;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_type;
    logic             in_imm;
    logic [7:0]       in_amt;
    logic [WIDTH-1:0] in_data;
    logic             in_cin;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_cout;
    logic             out_zero;
    logic             out_neg;
    logic [TAG_W-1:0] out_tag;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shift_pipe #(
        .WIDTH (WIDTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_type   (in_type),
        .in_imm    (in_imm),
        .in_amt    (in_amt),
        .in_data   (in_data),
        .in_cin    (in_cin),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cout  (out_cout),
        .out_zero  (out_zero),
        .out_neg   (out_neg),
        .out_tag   (out_tag)
    );

    // Result packed as {data, cout, zero, neg, tag}.
    function automatic logic [38:0] exp_res(input logic [31:0] d, input logic c,
                                            input logic z, input logic n,
                                            input logic [3:0] t);
        return {d, c, z, n, t};
    endfunction

    // Offers one op with out_ready=1, returns the result and the number of
    // cycles from acceptance to out_valid (10 means it never appeared).
    task automatic issue(input logic [1:0] typ, input logic imm, input logic [7:0] amt,
                         input logic [31:0] a, input logic cin, input logic [3:0] tag,
                         output logic [38:0] res, output int lat);
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_type   = typ;
        in_imm    = imm;
        in_amt    = amt;
        in_data   = a;
        in_cin    = cin;
        in_tag    = tag;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        res = {out_data, out_cout, out_zero, out_neg, out_tag};
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_type   = SH_LSL;
        in_imm    = 1'b0;
        in_amt    = '0;
        in_data   = '0;
        in_cin    = 1'b0;
        in_tag    = '0;
        out_ready = 1'b1;
        #1;
        total++;
        if ({out_valid, in_ready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_hold: got valid/ready=%b want 00", {out_valid, in_ready});
        end
        total++;
        if ({out_data, out_cout, out_zero, out_neg, out_tag} !== 39'd0) begin
            bad++;
            $display("FAIL reset_outs: got %h want 0", {out_data, out_cout, out_zero, out_neg, out_tag});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL reset_release: got valid/ready=%b want 01", {out_valid, in_ready});
        end
    endtask

    task automatic test_lsl();
        logic [38:0] res, exp;
        int lat;
        issue(SH_LSL, 1'b1, 8'd1, 32'hFFFFFFFF, 1'b0, 4'd1, res, lat);
        exp = exp_res(32'hFFFFFFFE, 1'b1, 1'b0, 1'b1, 4'd1);
        total++;
        if (res !== exp) begin bad++; $display("FAIL lsl_imm1: got %h want %h", res, exp); end
        total++;
        if (lat !== 2) begin bad++; $display("FAIL lsl_latency: got %0d want 2", lat); end
        issue(SH_LSL, 1'b0, 8'd32, 32'h00000001, 1'b0, 4'd2, res, lat);
        exp = exp_res(32'h0, 1'b1, 1'b1, 1'b0, 4'd2);
        total++;
        if (res !== exp) begin bad++; $display("FAIL lsl_reg32: got %h want %h", res, exp); end
        issue(SH_LSL, 1'b0, 8'd33, 32'hFFFFFFFF, 1'b1, 4'd3, res, lat);
        exp = exp_res(32'h0, 1'b0, 1'b1, 1'b0, 4'd3);
        total++;
        if (res !== exp) begin bad++; $display("FAIL lsl_reg33: got %h want %h", res, exp); end
        issue(SH_LSL, 1'b1, 8'd0, 32'h00000000, 1'b1, 4'd4, res, lat);
        exp = exp_res(32'h0, 1'b1, 1'b1, 1'b0, 4'd4);
        total++;
        if (res !== exp) begin bad++; $display("FAIL lsl_imm0: got %h want %h", res, exp); end
        issue(SH_LSL, 1'b1, 8'd4, 32'hF000000F, 1'b0, 4'd5, res, lat);
        exp = exp_res(32'h000000F0, 1'b1, 1'b0, 1'b0, 4'd5);
        total++;
        if (res !== exp) begin bad++; $display("FAIL lsl_imm4: got %h want %h", res, exp); end
    endtask

    task automatic test_lsr();
        logic [38:0] res, exp;
        int lat;
        issue(SH_LSR, 1'b1, 8'd0, 32'h80000FFF, 1'b0, 4'd6, res, lat);
        exp = exp_res(32'h0, 1'b1, 1'b1, 1'b0, 4'd6);
        total++;
        if (res !== exp) begin bad++; $display("FAIL lsr_imm0: got %h want %h", res, exp); end
        issue(SH_LSR, 1'b0, 8'd40, 32'h80000FFF, 1'b1, 4'd7, res, lat);
        exp = exp_res(32'h0, 1'b0, 1'b1, 1'b0, 4'd7);
        total++;
        if (res !== exp) begin bad++; $display("FAIL lsr_reg40: got %h want %h", res, exp); end
        issue(SH_LSR, 1'b1, 8'd4, 32'h000000F8, 1'b0, 4'd8, res, lat);
        exp = exp_res(32'h0000000F, 1'b1, 1'b0, 1'b0, 4'd8);
        total++;
        if (res !== exp) begin bad++; $display("FAIL lsr_imm4: got %h want %h", res, exp); end
    endtask

    task automatic test_asr();
        logic [38:0] res, exp;
        int lat;
        issue(SH_ASR, 1'b0, 8'd200, 32'h80000000, 1'b0, 4'd9, res, lat);
        exp = exp_res(32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 4'd9);
        total++;
        if (res !== exp) begin bad++; $display("FAIL asr_reg200: got %h want %h", res, exp); end
        issue(SH_ASR, 1'b1, 8'd16, 32'hFF0000FF, 1'b1, 4'd10, res, lat);
        exp = exp_res(32'hFFFFFF00, 1'b0, 1'b0, 1'b1, 4'd10);
        total++;
        if (res !== exp) begin bad++; $display("FAIL asr_imm16: got %h want %h", res, exp); end
        issue(SH_ASR, 1'b0, 8'd1, 32'h80000001, 1'b0, 4'd11, res, lat);
        exp = exp_res(32'hC0000000, 1'b1, 1'b0, 1'b1, 4'd11);
        total++;
        if (res !== exp) begin bad++; $display("FAIL asr_reg1: got %h want %h", res, exp); end
    endtask

    task automatic test_ror();
        logic [38:0] res, exp;
        int lat;
        issue(SH_ROR, 1'b1, 8'd0, 32'h00000FFF, 1'b1, 4'd12, res, lat);
        exp = exp_res(32'h800007FF, 1'b1, 1'b0, 1'b1, 4'd12);
        total++;
        if (res !== exp) begin bad++; $display("FAIL ror_rrx: got %h want %h", res, exp); end
        issue(SH_ROR, 1'b0, 8'd32, 32'h80000001, 1'b0, 4'd13, res, lat);
        exp = exp_res(32'h80000001, 1'b1, 1'b0, 1'b1, 4'd13);
        total++;
        if (res !== exp) begin bad++; $display("FAIL ror_reg32: got %h want %h", res, exp); end
        issue(SH_ROR, 1'b0, 8'd0, 32'h12345678, 1'b0, 4'd14, res, lat);
        exp = exp_res(32'h12345678, 1'b0, 1'b0, 1'b0, 4'd14);
        total++;
        if (res !== exp) begin bad++; $display("FAIL ror_reg0: got %h want %h", res, exp); end
        issue(SH_ROR, 1'b1, 8'd4, 32'h12345678, 1'b0, 4'd15, res, lat);
        exp = exp_res(32'h81234567, 1'b1, 1'b0, 1'b1, 4'd15);
        total++;
        if (res !== exp) begin bad++; $display("FAIL ror_imm4: got %h want %h", res, exp); end
        issue(SH_ROR, 1'b0, 8'd36, 32'h12345678, 1'b0, 4'd0, res, lat);
        exp = exp_res(32'h81234567, 1'b1, 1'b0, 1'b1, 4'd0);
        total++;
        if (res !== exp) begin bad++; $display("FAIL ror_reg36: got %h want %h", res, exp); end
    endtask

    // Streams LSL #t of 1 with tag t for t=0..3 while out_ready follows 1,0,0,1.
    task automatic test_back_to_back();
        logic [3:0]  ready_pat;
        logic        m_s1, m_s2, exp_rdy, s2_adv, s1_adv;
        logic        prev_stall;
        logic [38:0] prev_res, cur_res, exp;
        int          sent, rx, cyc;
        ready_pat  = 4'b1001;
        m_s1       = 1'b0;
        m_s2       = 1'b0;
        prev_stall = 1'b0;
        prev_res   = '0;
        sent       = 0;
        rx         = 0;
        cyc        = 0;
        while (rx < 4 && cyc < 20) begin
            @(negedge clk);
            out_ready = (cyc < 4) ? ready_pat[3 - cyc] : 1'b1;
            in_valid  = (sent < 4);
            in_type   = SH_LSL;
            in_imm    = 1'b1;
            in_amt    = 8'(sent);
            in_data   = 32'h00000001;
            in_cin    = 1'b0;
            in_tag    = 4'(sent);
            #1;
            exp_rdy = !m_s1 || !m_s2 || out_ready;
            total++;
            if (in_ready !== exp_rdy) begin
                bad++;
                $display("FAIL bp_in_ready c%0d: got %b want %b", cyc, in_ready, exp_rdy);
            end
            total++;
            if (out_valid !== m_s2) begin
                bad++;
                $display("FAIL bp_out_valid c%0d: got %b want %b", cyc, out_valid, m_s2);
            end
            cur_res = {out_data, out_cout, out_zero, out_neg, out_tag};
            if (prev_stall) begin
                total++;
                if (cur_res !== prev_res) begin
                    bad++;
                    $display("FAIL bp_hold c%0d: got %h want %h", cyc, cur_res, prev_res);
                end
            end
            if (m_s2 && out_ready) begin
                exp = exp_res(32'h1 << rx, 1'b0, 1'b0, 1'b0, 4'(rx));
                total++;
                if (cur_res !== exp) begin
                    bad++;
                    $display("FAIL bp_result%0d: got %h want %h", rx, cur_res, exp);
                end
                rx++;
            end
            prev_stall = m_s2 && !out_ready;
            prev_res   = cur_res;
            s2_adv = !m_s2 || out_ready;
            s1_adv = !m_s1 || s2_adv;
            if (s2_adv) m_s2 = m_s1;
            if (s1_adv) m_s1 = in_valid;
            if (in_valid && exp_rdy) sent++;
            cyc++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        total++;
        if (rx !== 4) begin bad++; $display("FAIL bp_count: got %0d want 4", rx); end
    endtask

    task automatic test_reset_mid();
        logic [38:0] res, exp;
        int lat;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_type   = SH_LSL;
        in_imm    = 1'b1;
        in_amt    = 8'd1;
        in_data   = 32'h00000003;
        in_cin    = 1'b0;
        in_tag    = 4'd5;
        @(negedge clk);
        in_tag = 4'd6;
        @(negedge clk);
        #1;
        total++;
        if ({out_valid, in_ready} !== 2'b10) begin
            bad++;
            $display("FAIL full_before_reset: got valid/ready=%b want 10", {out_valid, in_ready});
        end
        in_valid = 1'b0;
        reset    = 1'b1;
        #1;
        total++;
        if ({out_valid, in_ready, out_data, out_tag} !== 38'd0) begin
            bad++;
            $display("FAIL reset_mid: got %h want 0", {out_valid, in_ready, out_data, out_tag});
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++;
        if ({out_valid, in_ready} !== 2'b01) begin
            bad++;
            $display("FAIL reset_mid_release: got valid/ready=%b want 01", {out_valid, in_ready});
        end
        issue(SH_LSR, 1'b1, 8'd4, 32'h000000F8, 1'b0, 4'd7, res, lat);
        exp = exp_res(32'h0000000F, 1'b1, 1'b0, 1'b0, 4'd7);
        total++;
        if (res !== exp) begin bad++; $display("FAIL post_reset_op: got %h want %h", res, exp); end
        total++;
        if (lat !== 2) begin bad++; $display("FAIL post_reset_latency: got %0d want 2", lat); end
    endtask

    initial begin
        test_reset();
        test_lsl();
        test_lsr();
        test_asr();
        test_ror();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
